mulfp_req_arbiter: RTL and testbench



---
 rtl/mulfp_req_arbiter_if.sv | 28 ++
 rtl/mulfp_req_arbiter.sv | 111 +++++++++++
 tb/tb_mulfp_req_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mulfp_req_arbiter_if.sv
// Requester handshakes and multiplier issue/return bus shared by the
// arbiter (slave side) and its environment (master side).
interface mulfp_req_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [NREQ*DW-1:0] rsp_data;
   logic               mul_valid;
   logic [DW-1:0]      mul_a;
   logic [DW-1:0]      mul_b;
   logic [DW-1:0]      mul_result;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_result,
      output req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_result,
      input  req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
   );
endinterface

// File: rtl/mulfp_req_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier among NREQ requesters,
// with an ID tag pipeline steering each product back to its requester.
module mulfp_req_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   parameter int DW   = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   mulfp_req_arbiter_if.slave      bus,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);
   localparam int IW = $clog2(NREQ);
   // The product appears LAT cycles after the multiplier samples mul_valid,
   // which is one cycle after the tag enters, hence the extra stage.
   localparam int TAG_DEPTH = LAT + 1;

   logic [NREQ-1:0]    pending_q, pending_d;
   logic [IW-1:0]      ptr_q;
   logic               mulValid_q;
   logic [DW-1:0]      mulA_q, mulB_q;
   logic [IW-1:0]      grantId_q;
   logic [TAG_DEPTH-1:0] tagValid_q;
   logic [IW-1:0]      tagId_q [TAG_DEPTH];
   logic [NREQ-1:0]    rspValid_q, rspValid_d;
   logic [NREQ*DW-1:0] rspData_q, rspData_d;

   logic [NREQ-1:0]    eligible;
   logic [NREQ-1:0]    grantOneHot;
   logic               grantFound;
   logic [IW-1:0]      grantIdx;
   logic [IW:0]        candidate;
   logic [NREQ-1:0]    rspHandshake;

   always_comb begin
      eligible    = bus.req_valid & ~pending_q;
      grantFound  = 1'b0;
      grantIdx    = '0;
      grantOneHot = '0;
      candidate   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         candidate = {1'b0, ptr_q} + (IW+1)'(k);
         if (candidate >= (IW+1)'(NREQ)) begin
            candidate = candidate - (IW+1)'(NREQ);
         end
         if (!grantFound && eligible[candidate[IW-1:0]]) begin
            grantFound = 1'b1;
            grantIdx   = candidate[IW-1:0];
         end
      end
      if (grantFound) begin
         grantOneHot[grantIdx] = 1'b1;
      end
   end

   // Pending stays set until the response is consumed, so a returning tag
   // never lands on a requester whose response register is still occupied.
   always_comb begin
      rspHandshake = rspValid_q & bus.rsp_ready;
      pending_d    = (pending_q | grantOneHot) & ~rspHandshake;
      rspValid_d   = rspValid_q & ~rspHandshake;
      rspData_d    = rspData_q;
      if (tagValid_q[TAG_DEPTH-1]) begin
         rspValid_d[tagId_q[TAG_DEPTH-1]] = 1'b1;
         rspData_d[int'(tagId_q[TAG_DEPTH-1])*DW +: DW] = bus.mul_result;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pending_q  <= '0;
         ptr_q      <= IW'(NREQ-1);
         mulValid_q <= 1'b0;
         mulA_q     <= '0;
         mulB_q     <= '0;
         grantId_q  <= '0;
         tagValid_q <= '0;
         for (int k = 0; k < TAG_DEPTH; k++) begin
            tagId_q[k] <= '0;
         end
         rspValid_q <= '0;
         rspData_q  <= '0;
      end else begin
         pending_q  <= pending_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
         mulValid_q <= grantFound;
         if (grantFound) begin
            ptr_q     <= grantIdx;
            grantId_q <= grantIdx;
            mulA_q    <= bus.req_a[int'(grantIdx)*DW +: DW];
            mulB_q    <= bus.req_b[int'(grantIdx)*DW +: DW];
         end
         tagValid_q <= {tagValid_q[TAG_DEPTH-2:0], mulValid_q};
         tagId_q[0] <= grantId_q;
         for (int k = 1; k < TAG_DEPTH; k++) begin
            tagId_q[k] <= tagId_q[k-1];
         end
      end
   end

   assign bus.req_ready = grantOneHot;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_data  = rspData_q;
   assign bus.mul_valid = mulValid_q;
   assign bus.mul_a     = mulA_q;
   assign bus.mul_b     = mulB_q;
   assign grant_id      = grantId_q;
   assign busy          = |pending_q;
endmodule

// File: tb/tb_mulfp_req_arbiter.sv
// Randomized and directed bench for mulfp_req_arbiter against a
// transaction-level model (completion queue keyed by due cycle).
module tb_mulfp_req_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 3;
   localparam int DW   = 32;
   localparam int IW   = 2;
   localparam int VW   = NREQ*DW;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mulfp_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
   logic [IW-1:0] grantId;
   logic          busy;

   mulfp_req_arbiter #(.NREQ(NREQ), .LAT(LAT), .DW(DW)) dut (
      .ACLK     (clock),
      .ARESET   (reset),
      .bus      (bus),
      .grant_id (grantId),
      .busy     (busy)
   );

   // Normal-range FP32 multiply with truncation; good enough for the bench.
   function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      logic [9:0]  e;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (m[47]) begin
         m = m >> 1;
         e = e + 10'd1;
      end
      return {a[31] ^ b[31], e[7:0], m[45:23]};
   endfunction

   function automatic logic [31:0] randFp();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'($urandom_range(140, 110));
      return r;
   endfunction

   // Multiplier stand-in: product valid LAT cycles after it samples mul_valid,
   // garbage otherwise; deliberately not reset so stale results keep flowing.
   logic [DW-1:0] mulPipe [LAT+1];
   always @(posedge clock) begin
      mulPipe[0] <= bus.mul_valid ? fpMul(bus.mul_a, bus.mul_b) : 32'hDEADBEEF;
      for (int k = 1; k <= LAT; k++) mulPipe[k] <= mulPipe[k-1];
   end
   assign bus.mul_result = mulPipe[LAT];

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } arrival_t;

   arrival_t        inFlight[$];
   logic [NREQ-1:0] mPending, mRspValid;
   logic [VW-1:0]   mRspData;
   logic            mMulValid;
   logic [DW-1:0]   mMulA, mMulB;
   int              mPtr, mGrant, edgeNum;

   task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      vectorCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPending  = '0;
      mRspValid = '0;
      mRspData  = '0;
      mMulValid = 1'b0;
      mMulA     = '0;
      mMulB     = '0;
      mPtr      = NREQ-1;
      mGrant    = 0;
      inFlight.delete();
   endtask

   // One clock cycle: check registered state, drive inputs, check req_ready,
   // then advance the model across the coming edge.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [VW-1:0] a,
                                input logic [VW-1:0] b, input logic [NREQ-1:0] rr);
      int              winner;
      logic [NREQ-1:0] expReady, hs;
      @(negedge clock);
      checkOutput("rsp_valid", bus.rsp_valid, mRspValid);
      checkOutput("rsp_data", bus.rsp_data, mRspData);
      checkOutput("mul_valid", bus.mul_valid, mMulValid);
      checkOutput("mul_a", bus.mul_a, mMulA);
      checkOutput("mul_b", bus.mul_b, mMulB);
      checkOutput("grant_id", grantId, mGrant);
      checkOutput("busy", busy, |mPending);
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = rr;
      #1;
      winner = -1;
      for (int k = 1; k <= NREQ; k++) begin
         int c = (mPtr + k) % NREQ;
         if (winner < 0 && v[c] && !mPending[c]) winner = c;
      end
      expReady = '0;
      if (winner >= 0) expReady[winner] = 1'b1;
      checkOutput("req_ready", bus.req_ready, expReady);
      edgeNum++;
      hs        = mRspValid & rr;
      mPending  = mPending & ~hs;
      mRspValid = mRspValid & ~hs;
      for (int i = inFlight.size()-1; i >= 0; i--) begin
         if (inFlight[i].due == edgeNum) begin
            mRspValid[inFlight[i].id] = 1'b1;
            mRspData[inFlight[i].id*DW +: DW] = inFlight[i].data;
            inFlight.delete(i);
         end
      end
      if (winner >= 0) begin
         mPending[winner] = 1'b1;
         mPtr      = winner;
         mGrant    = winner;
         mMulValid = 1'b1;
         mMulA     = a[winner*DW +: DW];
         mMulB     = b[winner*DW +: DW];
         inFlight.push_back(arrival_t'{edgeNum + LAT + 2, winner, fpMul(mMulA, mMulB)});
      end else begin
         mMulValid = 1'b0;
      end
   endtask

   task automatic randomCycle(input logic [NREQ-1:0] forceValid, input logic [NREQ-1:0] rrMask);
      logic [VW-1:0]   a, b;
      logic [NREQ-1:0] rr;
      for (int i = 0; i < NREQ; i++) begin
         a[i*DW +: DW] = randFp();
         b[i*DW +: DW] = randFp();
         rr[i] = ($urandom_range(3, 0) != 0);
      end
      applyStimulus(NREQ'($urandom) | forceValid, a, b, rr & rrMask);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '1);
   endtask

   logic [VW-1:0] opA, opB;

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
      edgeNum = 0;
      modelReset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      idle(2);

      // Single request 1.5 * 2.0, held unconsumed to observe latency.
      opA = '0; opB = '0;
      opA[31:0] = 32'h3FC00000;
      opB[31:0] = 32'h40000000;
      applyStimulus(4'b0001, opA, opB, '0);
      for (int j = 1; j <= 7; j++) begin
         applyStimulus('0, '0, '0, '0);
         checkOutput("single_rsp_valid_timing", bus.rsp_valid[0], (j >= 6));
         checkOutput("single_busy", busy, 1'b1);
      end
      checkOutput("single_product", bus.rsp_data[31:0], 32'h40400000);
      idle(3);

      // All four requesters at once.
      for (int i = 0; i < NREQ; i++) begin
         opA[i*DW +: DW] = randFp();
         opB[i*DW +: DW] = randFp();
      end
      for (int i = 0; i < 4; i++) applyStimulus(4'hF, opA, opB, '1);
      idle(8);

      // Backpressure on requester 2 with product 2.0 * 2.0.
      opA = '0; opB = '0;
      opA[2*DW +: DW] = 32'h40000000;
      opB[2*DW +: DW] = 32'h40000000;
      applyStimulus(4'b0100, opA, opB, '1);
      for (int i = 0; i < 26; i++) randomCycle(4'b0100, 4'b1011);
      checkOutput("backpressure_product", bus.rsp_data[2*DW +: DW], 32'h40800000);
      checkOutput("backpressure_held", bus.rsp_valid[2], 1'b1);
      idle(8);

      // Fairness between requesters 1 and 3.
      for (int i = 0; i < 30; i++) applyStimulus(4'b1010, opA, opB, '1);
      idle(8);

      // Random traffic.
      for (int i = 0; i < 300; i++) randomCycle('0, '1);
      idle(10);

      // Back-to-back on requester 0 with valid held.
      opA[31:0] = randFp();
      opB[31:0] = randFp();
      for (int i = 0; i < 20; i++) applyStimulus(4'b0001, opA, opB, 4'b0001);
      idle(8);

      // Reset one cycle after issuing requester 1.
      applyStimulus(4'b0010, opA, opB, '1);
      @(negedge clock);
      bus.req_valid = '0;
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_rsp_valid", bus.rsp_valid, '0);
      checkOutput("rst_rsp_data", bus.rsp_data, '0);
      checkOutput("rst_mul_valid", bus.mul_valid, 1'b0);
      checkOutput("rst_mul_a", bus.mul_a, '0);
      checkOutput("rst_grant_id", grantId, '0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_req_ready", bus.req_ready, '0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      modelReset();
      idle(10);
      applyStimulus(4'hF, opA, opB, '1);
      checkOutput("post_reset_first_grant", bus.req_ready, 4'b0001);
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end
endmodule
